// File: rtl/dram_req_arbiter_pkg.sv
// Shared types and constants for the two-master SDRAM request arbiter.
package dram_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_BUSY,
        WAIT_DONE,
        RESP
    } state_e;

    typedef enum logic {
        GRANT_IF = 1'b0,
        GRANT_D  = 1'b1
    } grant_e;

    localparam logic [2:0] CTRL_B    = 3'b000;
    localparam logic [2:0] CTRL_H    = 3'b001;
    localparam logic [2:0] CTRL_W    = 3'b010;
    localparam logic [2:0] CTRL_ZEXT = 3'b100;

endpackage

// File: rtl/dram_req_arbiter_if.sv
// Master-port and controller-side bundle for dram_req_arbiter; the arbiter uses the slave view.
interface dram_req_arbiter_if;

    logic        i_if_req;
    logic [31:0] i_if_addr;
    logic        o_if_ack;
    logic [31:0] o_if_data;

    logic        i_d_req;
    logic        i_d_we;
    logic [31:0] i_d_addr;
    logic [31:0] i_d_wdata;
    logic [2:0]  i_d_ctrl;
    logic        o_d_ack;
    logic [31:0] o_d_rdata;

    logic        o_dram_rd_en;
    logic        o_dram_wr_en;
    logic [31:0] o_dram_addr;
    logic [31:0] o_dram_wdata;
    logic [2:0]  o_dram_ctrl;
    logic [31:0] i_dram_data;
    logic        i_dram_busy;
    logic        i_calib_done;
    logic        o_err;

    modport slave (
        input  i_if_req, i_if_addr,
        output o_if_ack, o_if_data,
        input  i_d_req, i_d_we, i_d_addr, i_d_wdata, i_d_ctrl,
        output o_d_ack, o_d_rdata,
        output o_dram_rd_en, o_dram_wr_en, o_dram_addr, o_dram_wdata, o_dram_ctrl,
        input  i_dram_data, i_dram_busy, i_calib_done,
        output o_err
    );

    modport master (
        output i_if_req, i_if_addr,
        input  o_if_ack, o_if_data,
        output i_d_req, i_d_we, i_d_addr, i_d_wdata, i_d_ctrl,
        input  o_d_ack, o_d_rdata,
        input  o_dram_rd_en, o_dram_wr_en, o_dram_addr, o_dram_wdata, o_dram_ctrl,
        output i_dram_data, i_dram_busy, i_calib_done,
        input  o_err
    );

endinterface

// File: rtl/dram_req_arbiter_arb.sv
// Two-way grant selection (round-robin or data-priority) plus the last-grant history register.
module rr_arb2
    import dram_pkg::*;
#(
    parameter int unsigned ARB_MODE = 0
) (
    input  logic   clk,
    input  logic   rst_x,
    input  logic   req_if,
    input  logic   req_d,
    input  logic   upd,
    input  grant_e upd_id,
    output grant_e gnt
);

    grant_e last_grant_q, last_grant_d;

    always_comb begin
        last_grant_d = last_grant_q;
        if (upd) last_grant_d = upd_id;
    end

    always_comb begin
        gnt = GRANT_IF;
        if (req_if && req_d) begin
            if (ARB_MODE == 1) gnt = GRANT_D;
            else               gnt = (last_grant_q == GRANT_IF) ? GRANT_D : GRANT_IF;
        end else if (req_d) begin
            gnt = GRANT_D;
        end
    end

    always_ff @(posedge clk or negedge rst_x) begin
        if (!rst_x) last_grant_q <= GRANT_IF;
        else        last_grant_q <= last_grant_d;
    end

endmodule

// File: rtl/dram_req_arbiter.sv
// Two-master SDRAM front end: arbitrates ifetch vs data, issues one strobe per transaction,
// holds the request fields until the controller finishes, then acks the granted master.
module dram_req_arbiter
    import dram_pkg::*;
#(
    parameter int unsigned ARB_MODE = 0,
    parameter int unsigned BUSY_TO  = 15
) (
    input  logic               clk,
    input  logic               rst_x,
    dram_req_arbiter_if.slave  bus
);

    localparam logic [7:0] TO_CNT = 8'(BUSY_TO);

    state_e      state_q, state_d;
    grant_e      gnt_id_q, gnt_id_d, arb_gnt;
    logic [7:0]  cnt_q, cnt_d;
    logic        we_q, we_d;
    logic        rd_en_q, rd_en_d, wr_en_q, wr_en_d;
    logic [31:0] addr_q, addr_d, wdata_q, wdata_d;
    logic [2:0]  ctrl_q, ctrl_d;
    logic        if_ack_q, if_ack_d, d_ack_q, d_ack_d;
    logic [31:0] if_data_q, if_data_d, d_rdata_q, d_rdata_d;
    logic        err_q, err_d;

    rr_arb2 #(.ARB_MODE(ARB_MODE)) u_arb (
        .clk    (clk),
        .rst_x  (rst_x),
        .req_if (bus.i_if_req),
        .req_d  (bus.i_d_req),
        .upd    (state_q == RESP),
        .upd_id (gnt_id_q),
        .gnt    (arb_gnt)
    );

    always_comb begin
        state_d   = state_q;
        gnt_id_d  = gnt_id_q;
        cnt_d     = cnt_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        ctrl_d    = ctrl_q;
        if_data_d = if_data_q;
        d_rdata_d = d_rdata_q;
        err_d     = err_q;
        rd_en_d   = 1'b0;
        wr_en_d   = 1'b0;
        if_ack_d  = 1'b0;
        d_ack_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.i_calib_done && !bus.i_dram_busy && (bus.i_if_req || bus.i_d_req)) begin
                    gnt_id_d = arb_gnt;
                    cnt_d    = '0;
                    if (arb_gnt == GRANT_D) begin
                        addr_d  = bus.i_d_addr;
                        wdata_d = bus.i_d_wdata;
                        ctrl_d  = bus.i_d_ctrl;
                        we_d    = bus.i_d_we;
                    end else begin
                        addr_d  = bus.i_if_addr;
                        wdata_d = '0;
                        ctrl_d  = CTRL_W;
                        we_d    = 1'b0;
                    end
                    rd_en_d = ~we_d;
                    wr_en_d = we_d;
                    state_d = WAIT_BUSY;
                end
            end
            WAIT_BUSY: begin
                if (bus.i_dram_busy) begin
                    state_d = WAIT_DONE;
                end else if (cnt_q == TO_CNT) begin
                    err_d   = 1'b1;
                    rd_en_d = ~we_q;
                    wr_en_d = we_q;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            WAIT_DONE: begin
                // Ack is registered on entry to RESP so the master drops req before IDLE samples it.
                if (!bus.i_dram_busy) begin
                    if (gnt_id_q == GRANT_IF) begin
                        if_data_d = bus.i_dram_data;
                        if_ack_d  = 1'b1;
                    end else begin
                        if (!we_q) d_rdata_d = bus.i_dram_data;
                        d_ack_d = 1'b1;
                    end
                    state_d = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_x) begin
        if (!rst_x) begin
            state_q   <= IDLE;
            gnt_id_q  <= GRANT_IF;
            cnt_q     <= '0;
            we_q      <= 1'b0;
            rd_en_q   <= 1'b0;
            wr_en_q   <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            ctrl_q    <= '0;
            if_ack_q  <= 1'b0;
            d_ack_q   <= 1'b0;
            if_data_q <= '0;
            d_rdata_q <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            gnt_id_q  <= gnt_id_d;
            cnt_q     <= cnt_d;
            we_q      <= we_d;
            rd_en_q   <= rd_en_d;
            wr_en_q   <= wr_en_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            ctrl_q    <= ctrl_d;
            if_ack_q  <= if_ack_d;
            d_ack_q   <= d_ack_d;
            if_data_q <= if_data_d;
            d_rdata_q <= d_rdata_d;
            err_q     <= err_d;
        end
    end

    assign bus.o_dram_rd_en = rd_en_q;
    assign bus.o_dram_wr_en = wr_en_q;
    assign bus.o_dram_addr  = addr_q;
    assign bus.o_dram_wdata = wdata_q;
    assign bus.o_dram_ctrl  = ctrl_q;
    assign bus.o_if_ack     = if_ack_q;
    assign bus.o_if_data    = if_data_q;
    assign bus.o_d_ack      = d_ack_q;
    assign bus.o_d_rdata    = d_rdata_q;
    assign bus.o_err        = err_q;

endmodule

// File: tb/tb_dram_req_arbiter.sv
// Scoreboard bench for dram_req_arbiter with a small SDRAM controller model.
module tb_dram_req_arbiter;
    import dram_pkg::*;

    localparam int unsigned TO = 15;

    typedef struct {
        bit          port;
        logic [31:0] data;
    } ack_t;

    logic clk = 1'b0;
    logic rst_x;
    always #5 clk = ~clk;

    dram_req_arbiter_if bus();

    dram_req_arbiter #(.ARB_MODE(0), .BUSY_TO(TO)) dut (
        .clk   (clk),
        .rst_x (rst_x),
        .bus   (bus)
    );

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;
    ack_t exp_q[$];
    ack_t obs_q[$];
    logic [31:0] last_d = '0;

    bit          model_on   = 1'b1;
    int unsigned model_len  = 4;
    logic [31:0] model_base = '0;
    int unsigned m_cnt;
    logic [31:0] m_addr;

    // Controller model: busy rises the cycle after a strobe, stays up model_len cycles,
    // then presents model_base ^ addr as read data.
    always @(posedge clk or negedge rst_x) begin
        if (!rst_x) begin
            bus.i_dram_busy <= 1'b0;
            bus.i_dram_data <= '0;
            m_cnt           <= 0;
            m_addr          <= '0;
        end else if ((bus.o_dram_rd_en || bus.o_dram_wr_en) && model_on) begin
            bus.i_dram_busy <= 1'b1;
            m_cnt           <= model_len - 1;
            m_addr          <= bus.o_dram_addr;
            bus.i_dram_data <= 32'hBAD0BAD0;
        end else if (bus.i_dram_busy) begin
            if (m_cnt == 0) begin
                bus.i_dram_busy <= 1'b0;
                bus.i_dram_data <= model_base ^ m_addr;
            end else begin
                m_cnt <= m_cnt - 1;
            end
        end
    end

    int unsigned rd_cnt = 0, wr_cnt = 0, overlap = 0, hold_viol = 0;
    logic [31:0] s_addr = '0, s_wdata = '0;
    logic [2:0]  s_ctrl = '0;

    always @(negedge clk) begin
        if (bus.o_dram_rd_en || bus.o_dram_wr_en) begin
            if (bus.o_dram_rd_en) rd_cnt++;
            if (bus.o_dram_wr_en) wr_cnt++;
            if ((bus.o_dram_rd_en && bus.o_dram_wr_en) || bus.i_dram_busy) overlap++;
            s_addr  = bus.o_dram_addr;
            s_wdata = bus.o_dram_wdata;
            s_ctrl  = bus.o_dram_ctrl;
        end else if (bus.i_dram_busy &&
                     (bus.o_dram_addr !== s_addr || bus.o_dram_wdata !== s_wdata ||
                      bus.o_dram_ctrl !== s_ctrl)) begin
            hold_viol++;
        end
    end

    task automatic cycle();
        @(negedge clk);
        #1;
        if (bus.o_if_ack) begin
            obs_q.push_back('{1'b0, bus.o_if_data});
            bus.i_if_req = 1'b0;
        end
        if (bus.o_d_ack) begin
            obs_q.push_back('{1'b1, bus.o_d_rdata});
            bus.i_d_req = 1'b0;
        end
    endtask

    task automatic run_acks(input int unsigned n, input int unsigned budget, output bit timed_out);
        int unsigned k = 0;
        while (obs_q.size() < n && k < budget) begin
            cycle();
            k++;
        end
        timed_out = (obs_q.size() < n);
        repeat (5) cycle();
    endtask

    task automatic test_reset();
        rst_x = 1'b0;
        bus.i_if_req = 1'b0; bus.i_if_addr = '0;
        bus.i_d_req = 1'b0; bus.i_d_we = 1'b0; bus.i_d_addr = '0;
        bus.i_d_wdata = '0; bus.i_d_ctrl = '0; bus.i_calib_done = 1'b0;
        #2;
        n_cmp++;
        if ({bus.o_dram_rd_en, bus.o_dram_wr_en, bus.o_if_ack, bus.o_d_ack, bus.o_err} !== 5'b0) begin
            n_bad++;
            $display("FAIL reset_ctl got=%b want=00000",
                     {bus.o_dram_rd_en, bus.o_dram_wr_en, bus.o_if_ack, bus.o_d_ack, bus.o_err});
        end
        n_cmp++;
        if ({bus.o_dram_addr, bus.o_dram_wdata, bus.o_dram_ctrl} !== 67'h0) begin
            n_bad++;
            $display("FAIL reset_bus got=%h want=0", {bus.o_dram_addr, bus.o_dram_wdata, bus.o_dram_ctrl});
        end
        n_cmp++;
        if ({bus.o_if_data, bus.o_d_rdata} !== 64'h0) begin
            n_bad++;
            $display("FAIL reset_rdata got=%h want=0", {bus.o_if_data, bus.o_d_rdata});
        end
        repeat (3) @(negedge clk);
        #1;
        rst_x = 1'b1;
        bus.i_calib_done = 1'b1;
        repeat (2) cycle();
    endtask

    task automatic test_ifetch();
        int unsigned r0 = rd_cnt;
        bit to;
        ack_t e, o;
        model_len  = 6;
        model_base = 32'hDEADBEEF ^ 32'h100;
        exp_q.push_back('{1'b0, 32'hDEADBEEF});
        bus.i_if_addr = 32'h100;
        bus.i_if_req  = 1'b1;
        run_acks(1, 100, to);
        n_cmp++;
        if (to) begin n_bad++; $display("FAIL ifetch_timeout got=%0d want=0", to); end
        e = exp_q.pop_front();
        n_cmp++;
        if (obs_q.size() == 0) begin
            n_bad++; $display("FAIL ifetch_ack got=none want=%0d/%h", e.port, e.data);
        end else begin
            o = obs_q.pop_front();
            if ({o.port, o.data} !== {e.port, e.data}) begin
                n_bad++; $display("FAIL ifetch_ack got=%0d/%h want=%0d/%h", o.port, o.data, e.port, e.data);
            end
        end
        n_cmp++;
        if (obs_q.size() != 0) begin n_bad++; $display("FAIL ifetch_extra_ack got=%0d want=0", obs_q.size()); obs_q.delete(); end
        n_cmp++;
        if (rd_cnt - r0 != 1) begin n_bad++; $display("FAIL ifetch_strobes got=%0d want=1", rd_cnt - r0); end
        n_cmp++;
        if ({s_ctrl, s_addr} !== {3'b010, 32'h100}) begin
            n_bad++; $display("FAIL ifetch_ctrl_addr got=%b/%h want=010/00000100", s_ctrl, s_addr);
        end
    endtask

    task automatic test_both();
        int unsigned r0 = rd_cnt, ov0 = overlap;
        bit to;
        ack_t e, o;
        model_len  = 3;
        model_base = 32'h5A5A0000;
        exp_q.push_back('{1'b1, 32'h5A5A0040});
        exp_q.push_back('{1'b0, 32'h5A5A0080});
        bus.i_d_we = 1'b0; bus.i_d_addr = 32'h40; bus.i_d_ctrl = CTRL_W;
        bus.i_if_addr = 32'h80;
        bus.i_d_req = 1'b1;
        bus.i_if_req = 1'b1;
        run_acks(2, 200, to);
        n_cmp++;
        if (to) begin n_bad++; $display("FAIL both_timeout got=%0d want=0", to); end
        for (int k = 0; k < 2; k++) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (obs_q.size() == 0) begin
                n_bad++; $display("FAIL both_ack%0d got=none want=%0d/%h", k, e.port, e.data);
            end else begin
                o = obs_q.pop_front();
                if ({o.port, o.data} !== {e.port, e.data}) begin
                    n_bad++; $display("FAIL both_ack%0d got=%0d/%h want=%0d/%h", k, o.port, o.data, e.port, e.data);
                end
            end
        end
        n_cmp++;
        if (obs_q.size() != 0) begin n_bad++; $display("FAIL both_extra_ack got=%0d want=0", obs_q.size()); obs_q.delete(); end
        n_cmp++;
        if (rd_cnt - r0 != 2 || overlap != ov0) begin
            n_bad++; $display("FAIL both_strobes got=%0d/%0d want=2/0", rd_cnt - r0, overlap - ov0);
        end
        last_d = 32'h5A5A0040;
    endtask

    task automatic test_store();
        int unsigned r0 = rd_cnt, w0 = wr_cnt, h0 = hold_viol;
        bit to;
        ack_t e, o;
        model_len  = 8;
        model_base = 32'hCAFE0000;
        exp_q.push_back('{1'b1, last_d});
        bus.i_d_we = 1'b1; bus.i_d_addr = 32'h203; bus.i_d_ctrl = CTRL_W;
        bus.i_d_wdata = 32'h11223344;
        bus.i_d_req = 1'b1;
        run_acks(1, 100, to);
        bus.i_d_we = 1'b0;
        n_cmp++;
        if (to) begin n_bad++; $display("FAIL store_timeout got=%0d want=0", to); end
        e = exp_q.pop_front();
        n_cmp++;
        if (obs_q.size() == 0) begin
            n_bad++; $display("FAIL store_ack got=none want=%0d/%h", e.port, e.data);
        end else begin
            o = obs_q.pop_front();
            if ({o.port, o.data} !== {e.port, e.data}) begin
                n_bad++; $display("FAIL store_ack got=%0d/%h want=%0d/%h", o.port, o.data, e.port, e.data);
            end
        end
        n_cmp++;
        if (obs_q.size() != 0) begin n_bad++; $display("FAIL store_extra_ack got=%0d want=0", obs_q.size()); obs_q.delete(); end
        n_cmp++;
        if (wr_cnt - w0 != 1 || rd_cnt != r0) begin
            n_bad++; $display("FAIL store_strobes got=wr%0d/rd%0d want=wr1/rd0", wr_cnt - w0, rd_cnt - r0);
        end
        n_cmp++;
        if ({s_addr, s_wdata, s_ctrl} !== {32'h203, 32'h11223344, 3'b010}) begin
            n_bad++; $display("FAIL store_fields got=%h/%h/%b want=00000203/11223344/010", s_addr, s_wdata, s_ctrl);
        end
        n_cmp++;
        if (hold_viol != h0) begin n_bad++; $display("FAIL store_hold got=%0d want=0", hold_viol - h0); end
    endtask

    task automatic test_calib();
        int unsigned r0 = rd_cnt;
        bit to;
        ack_t e, o;
        model_len  = 4;
        model_base = 32'h0F0F0000;
        bus.i_calib_done = 1'b0;
        bus.i_d_we = 1'b0; bus.i_d_addr = 32'h300; bus.i_d_ctrl = CTRL_W | CTRL_ZEXT;
        exp_q.push_back('{1'b1, 32'h0F0F0300});
        bus.i_d_req = 1'b1;
        repeat (50) cycle();
        n_cmp++;
        if (rd_cnt != r0 || obs_q.size() != 0) begin
            n_bad++; $display("FAIL calib_block got=%0d strobes/%0d acks want=0/0", rd_cnt - r0, obs_q.size());
        end
        bus.i_calib_done = 1'b1;
        cycle();
        n_cmp++;
        if (bus.o_dram_rd_en !== 1'b1) begin n_bad++; $display("FAIL calib_grant got=%b want=1", bus.o_dram_rd_en); end
        run_acks(1, 100, to);
        n_cmp++;
        if (to) begin n_bad++; $display("FAIL calib_timeout got=%0d want=0", to); end
        e = exp_q.pop_front();
        n_cmp++;
        if (obs_q.size() == 0) begin
            n_bad++; $display("FAIL calib_ack got=none want=%0d/%h", e.port, e.data);
        end else begin
            o = obs_q.pop_front();
            if ({o.port, o.data} !== {e.port, e.data} || s_ctrl !== 3'b110) begin
                n_bad++; $display("FAIL calib_ack got=%0d/%h/%b want=%0d/%h/110", o.port, o.data, s_ctrl, e.port, e.data);
            end
        end
        last_d = 32'h0F0F0300;
    endtask

    task automatic test_timeout();
        int unsigned r0 = rd_cnt;
        bit to;
        ack_t e, o;
        model_on   = 1'b0;
        model_len  = 3;
        model_base = 32'h77770000;
        bus.i_d_we = 1'b0; bus.i_d_addr = 32'h400; bus.i_d_ctrl = CTRL_W;
        exp_q.push_back('{1'b1, 32'h77770400});
        bus.i_d_req = 1'b1;
        cycle();
        n_cmp++;
        if ({bus.o_dram_rd_en, bus.o_err} !== 2'b10) begin
            n_bad++; $display("FAIL to_first_strobe got=%b want=10", {bus.o_dram_rd_en, bus.o_err});
        end
        repeat (TO) cycle();
        n_cmp++;
        if ({bus.o_dram_rd_en, bus.o_err} !== 2'b00) begin
            n_bad++; $display("FAIL to_before_limit got=%b want=00", {bus.o_dram_rd_en, bus.o_err});
        end
        cycle();
        n_cmp++;
        if ({bus.o_dram_rd_en, bus.o_err} !== 2'b11) begin
            n_bad++; $display("FAIL to_err_reissue got=%b want=11", {bus.o_dram_rd_en, bus.o_err});
        end
        model_on = 1'b1;
        run_acks(1, 100, to);
        n_cmp++;
        if (to) begin n_bad++; $display("FAIL to_timeout got=%0d want=0", to); end
        e = exp_q.pop_front();
        n_cmp++;
        if (obs_q.size() == 0) begin
            n_bad++; $display("FAIL to_ack got=none want=%0d/%h", e.port, e.data);
        end else begin
            o = obs_q.pop_front();
            if ({o.port, o.data} !== {e.port, e.data}) begin
                n_bad++; $display("FAIL to_ack got=%0d/%h want=%0d/%h", o.port, o.data, e.port, e.data);
            end
        end
        n_cmp++;
        if (bus.o_err !== 1'b1 || rd_cnt - r0 != 2) begin
            n_bad++; $display("FAIL to_sticky got=err%b/strobes%0d want=err1/strobes2", bus.o_err, rd_cnt - r0);
        end
    endtask

    task automatic test_reset_mid();
        bit to;
        bit seen = 1'b0;
        ack_t e, o;
        model_len  = 10;
        model_base = 32'h12340000;
        bus.i_d_we = 1'b0; bus.i_d_addr = 32'h500; bus.i_d_ctrl = CTRL_W;
        bus.i_d_req = 1'b1;
        for (int k = 0; k < 20 && !seen; k++) begin
            cycle();
            seen = bus.i_dram_busy;
        end
        n_cmp++;
        if (!seen) begin n_bad++; $display("FAIL rmid_busy got=0 want=1"); end
        repeat (2) cycle();
        #2;
        rst_x = 1'b0;
        #1;
        n_cmp++;
        if ({bus.o_dram_rd_en, bus.o_dram_wr_en, bus.o_if_ack, bus.o_d_ack, bus.o_err} !== 5'b0) begin
            n_bad++;
            $display("FAIL rmid_ctl got=%b want=00000",
                     {bus.o_dram_rd_en, bus.o_dram_wr_en, bus.o_if_ack, bus.o_d_ack, bus.o_err});
        end
        n_cmp++;
        if ({bus.o_dram_addr, bus.o_dram_wdata, bus.o_dram_ctrl, bus.o_if_data, bus.o_d_rdata} !== 131'h0) begin
            n_bad++;
            $display("FAIL rmid_data got=%h/%h/%b/%h/%h want=0", bus.o_dram_addr, bus.o_dram_wdata,
                     bus.o_dram_ctrl, bus.o_if_data, bus.o_d_rdata);
        end
        bus.i_d_req = 1'b0;
        @(negedge clk);
        #1;
        rst_x = 1'b1;
        model_len  = 2;
        exp_q.push_back('{1'b0, 32'h12340600});
        bus.i_if_addr = 32'h600;
        bus.i_if_req  = 1'b1;
        run_acks(1, 100, to);
        n_cmp++;
        if (to) begin n_bad++; $display("FAIL rmid_timeout got=%0d want=0", to); end
        e = exp_q.pop_front();
        n_cmp++;
        if (obs_q.size() == 0) begin
            n_bad++; $display("FAIL rmid_ack got=none want=%0d/%h", e.port, e.data);
        end else begin
            o = obs_q.pop_front();
            if ({o.port, o.data} !== {e.port, e.data}) begin
                n_bad++; $display("FAIL rmid_ack got=%0d/%h want=%0d/%h", o.port, o.data, e.port, e.data);
            end
        end
        n_cmp++;
        if (obs_q.size() != 0 || bus.o_err !== 1'b0) begin
            n_bad++; $display("FAIL rmid_after got=acks%0d/err%b want=acks0/err0", obs_q.size(), bus.o_err);
        end
    endtask

    initial begin
        test_reset();
        test_ifetch();
        test_both();
        test_store();
        test_calib();
        test_timeout();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
